// File: rtl/serial_cla_sequencer.sv
// serial_cla_sequencer: time-shares one W-bit lookahead slice across N-bit operands, one chunk per clock (ports: clk, reset, start/a/b/cin in; busy/done/sum/cout/ovf out)
module serial_cla_sequencer #(
  parameter int N = 32,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int NC = N / W;
  localparam int IW = NC > 1 ? $clog2(NC) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [N-1:0]  ra, rb;
  logic [W-1:0]  ca, cb, g, p, s;
  logic [W:0]    c;
  function automatic logic [W:0] lookahead(input logic [W-1:0] gg, input logic [W-1:0] pp, input logic c0);
    logic [W:0] r;
    r[0] = c0;
    for (int i = 0; i < W; i++) r[i+1] = gg[i] | (pp[i] & r[i]);
    return r;
  endfunction
  always_comb begin
    ca = ra[idx*W +: W];
    cb = rb[idx*W +: W];
    g  = ca & cb;
    p  = ca ^ cb;
    c  = lookahead(g, p, carry);
    s  = p ^ c[W-1:0];
  end
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ra    <= a;
          rb    <= b;
          carry <= cin;
          idx   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          sum[idx*W +: W] <= s;
          carry <= c[W];
          if (idx == IW'(NC - 1)) begin
            cout  <= c[W];
            ovf   <= c[W-1] ^ c[W];
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_cla_sequencer.sv
// tb_serial_cla_sequencer: table-driven and sequence checks of the serial carry-lookahead adder controller
module tb_serial_cla_sequencer;
  localparam int N = 32;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         reset, start, cin;
  logic [N-1:0] a, b, sum;
  logic         busy, done, cout, ovf;
  int           tests = 0;
  int           fails = 0;
  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  serial_cla_sequencer #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );
  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Launch an operation and wait for done; cyc is the cycle number in which done was seen
  task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc, output int cyc, output int busy_low);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_low = 0;
    while (!done && cyc < 20) begin
      if (!busy) busy_low++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (!busy) busy_low++;
  endtask
  initial begin
    int cyc, bl, pulses;
    logic [N-1:0] seen;
    vecs[0] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[6] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", N'(busy), 0);
    chk("reset done", N'(done), 0);
    chk("reset sum", sum, 0);
    chk("reset cout/ovf", N'({cout, ovf}), 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, cyc, bl);
      chk($sformatf("v%0d latency", i), N'(cyc), 9);
      chk($sformatf("v%0d busy gaps", i), N'(bl), 0);
      chk($sformatf("v%0d sum", i), sum, vecs[i].sum);
      chk($sformatf("v%0d cout", i), N'(cout), N'(vecs[i].cout));
      chk($sformatf("v%0d ovf", i), N'(ovf), N'(vecs[i].ovf));
      @(negedge clk);
      chk($sformatf("v%0d idle after", i), N'({busy, done}), 0);
    end
    // start and operand changes mid-run must be ignored
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pulses = 0; seen = '0; cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin start = 1'b1; a = 32'hFFFFFFFF; b = 32'h0000FFFF; cin = 1'b1; end
      if (k == 4) begin start = 1'b0; b = 32'h12121212; end
      if (done) begin pulses++; seen = sum; cyc = k; end
      @(posedge clk);
      @(negedge clk);
    end
    chk("busyprot pulses", N'(pulses), 1);
    chk("busyprot sum", seen, 32'h23456789);
    chk("busyprot latency", N'(cyc), 9);
    // asynchronous reset in the middle of a run
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", N'(busy), 0);
    chk("abort done", N'(done), 0);
    chk("abort sum", sum, 0);
    chk("abort cout/ovf", N'({cout, ovf}), 0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort no done", N'(pulses), 0);
    run_op(32'd5, 32'd3, 1'b0, cyc, bl);
    chk("post-reset latency", N'(cyc), 9);
    chk("post-reset sum", sum, 32'd8);
    // back-to-back with start held high through the done cycle
    @(negedge clk);
    a = 32'h0000000F; b = 32'h00000001; cin = 1'b0; start = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(posedge clk);
      @(negedge clk);
      cyc = k;
    end
    chk("b2b first latency", N'(cyc), 9);
    chk("b2b first sum", sum, 32'h00000010);
    a = 32'h80000000; b = 32'h80000000;
    @(posedge clk);
    @(negedge clk);
    chk("b2b idle gap", N'({busy, done}), 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b accepted", N'(busy), 1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("b2b second latency", N'(cyc), 9);
    chk("b2b second sum", sum, 32'h00000000);
    chk("b2b second cout/ovf", N'({cout, ovf}), 32'd3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_cla_sequencer.md
Name: serial_cla_sequencer

Overview:
Multi-cycle adder controller. It sequences one W-bit carry-lookahead slice across an N-bit operand pair, one W-bit chunk per clock, from LSB to MSB. The carry is held in a register between chunks. The block sits between a requester (start/done handshake) and the generate/propagate carry logic, and time-shares a single lookahead slice in place of a full-width adder.

Parameters:
N, 32, operand/result width in bits; must be an exact multiple of W.
W, 4, chunk width processed per cycle (lookahead slice width).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
a  input  N  operand A; captured on the accepted start.
b  input  N  operand B; captured on the accepted start.
cin  input  1  carry-in; captured on the accepted start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; result valid.
sum  output  N  result; held stable after done until the next accepted start.
cout  output  1  carry out of bit N-1.
ovf  output  1  signed overflow = carry into bit N-1 XOR cout.

Behaviour:
- Reset (async, any state): state=IDLE, chunk index=0, carry reg=0, operand regs=0, sum=0, cout=0, ovf=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
  - IDLE: on a clk edge with start=1, capture a, b, cin (cin loads the carry reg), set index=0, go to RUN. With start=0, stay in IDLE.
  - RUN: each edge processes chunk idx, i.e. bits [idx*W +: W].
    - Per bit: g=a&b, p=a^b.
    - Lookahead carries: c0=carry reg, c(i+1)=g(i) | p(i)&c(i).
    - Sum bits: p(i)^c(i), written into sum[idx*W +: W].
    - carry reg <= c(W).
    - On the last chunk (idx=N/W-1): cout <= c(W), ovf <= c(W-1)^c(W), go to DONE. Otherwise idx <= idx+1.
  - DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Latency: start sampled at edge 0. Chunks are processed at edges 1..N/W. done is high in the cycle after edge N/W; with defaults, done is high during cycle 9.
- busy is high from the cycle after the accepted start through the DONE cycle inclusive.
- start while busy (RUN or DONE) is ignored: no recapture, no queueing. Changes on a, b, cin while busy have no effect.
- Back-to-back: start asserted in the cycle done=1 is ignored. The requester reissues start once busy=0, and it is accepted in the IDLE cycle.
- sum, cout and ovf are registered outputs.
  - During RUN, sum upper chunks still hold the previous result until overwritten; only the value at done is defined.
  - cout and ovf keep the previous result until the last chunk is processed.
- Wrap-around: the index never exceeds N/W-1; the addition is modulo 2^N, with the carry exposed on cout.
- Reset asserted mid-RUN aborts immediately to the reset values. No done pulse is generated for the aborted operation.
- done and busy are decoded from the registered state, so they are glitch-free.

Test Plan:
1. Zero case: a=0, b=0, cin=0, start pulse -> done in cycle 9, sum=0x00000000, cout=0, ovf=0, busy high cycles 1-9.
2. Full ripple: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0. This exercises the carry reg across all 8 chunks.
3. Cross-chunk carry and overflow:
   - a=0x0000000F, b=0x00000001, cin=0 -> sum=0x00000010, cout=0.
   - a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, ovf=1, cout=0.
4. Busy protection: a=0x12345678, b=0x11111111. Pulse start again in cycle 3 with a=0xFFFFFFFF, and change b mid-run -> sum=0x23456789, exactly one done pulse.
5. Reset mid-operation: assert reset asynchronously (off-edge) in cycle 4 -> busy, done, sum, cout and ovf go to 0 immediately. After release, a fresh start with a=5, b=3 gives sum=8 with a normal 9-cycle latency.
6. Back-to-back: a start held high through the done cycle is ignored there. It is accepted in the next IDLE cycle, and the second result matches the new operands.
